req_encoder8to3: RTL and testbench
==================================

// Module: req_encoder8to3
// PURPOSE
//  Sequential 8-to-3 priority encoder: the encode-side counterpart of the 3-to-8 decoder.
//  Captures request lines into a sticky pending register and presents one 3-bit code
//  at a time with valid/ack handshake. Highest index wins.
//  Sits between request sources (interrupt/event lines) and a consumer that services one
//  index per transaction; the consumer may feed code_out back into decoder3to8.
// PARAMETERS
//  N  8  number of request lines (fixed at 8 for this block)
//  W  3  code width, $clog2(N)
// PORTS
//  clk          in   1  single clock, all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  req_in       in   8  request pulses/levels; any 1 sets the matching pending bit
//  en           in   1  grant enable; 0 = keep collecting requests, issue no new grant
//  ack_in       in   1  consumer accepts current code (valid only when valid_out=1)
//  code_out     out  3  index of granted request, stable while valid_out=1
//  valid_out    out  1  code_out holds an un-acked grant
//  pending_out  out  8  current pending register (after this cycle's update)
//  busy_out     out  1  1 when pending_out != 0 or valid_out = 1
// BEHAVIOUR
//  Reset (rst=1 at edge): pending=8'h00, code_out=3'd0, valid_out=0, state=IDLE; busy_out=0.
//  pending update every cycle: pending <= (pending & ~clr_mask) | req_in,
//   clr_mask = one-hot(code_out) when valid_out&&ack_in, else 0. Set beats clear on same bit.
//  FSM, 2 states:
//   IDLE: valid_out=0. If en && pending!=0: code_out <= highest set index of pending,
//         valid_out <= 1, -> GRANT. Otherwise stay. req_in this cycle NOT seen until next.
//   GRANT: valid_out=1, code_out frozen. On ack_in: clear bit, valid_out <= 0, -> IDLE.
//          en=0 in GRANT does not withdraw the grant.
//  Latency: req_in bit at edge t -> pending at t+1 -> valid_out at t+2 (if IDLE, en=1).
//  Ack at edge t -> valid_out=0 at t+1 -> next grant earliest at t+2 (one bubble cycle).
//  ack_in while valid_out=0: ignored, no state change.
//  Repeated req on a bit already pending: no effect (no counting, no overflow flag).
//  Higher-priority request arriving during GRANT does not preempt; takes effect next IDLE.
//  rst asserted mid-transaction: grant dropped, pending cleared, no ack required.
//  busy_out is combinational from registered state only (no req_in path).
// STRUCTURE
//  Package req_enc_pkg: localparams N=8, W=3; state typedef {IDLE, GRANT}.
//  Sub-module prio_enc8: combinational 8->3 highest-index encoder with any-bit flag;
//   instantiated once on the pending register. Top holds pending reg, FSM, output regs.
// TESTING
//  1 rst=1 2 cycles, req_in=8'hFF during rst -> pending=0, valid_out=0, code_out=0 after.
//  2 req_in=8'b0000_0100 one cycle, en=1, ack held 0 -> valid_out=1, code_out=3'd2 at t+2,
//    held 5 cycles; ack 1 cycle -> valid_out=0, pending_out=8'h00, busy_out=0.
//  3 req_in=8'b1010_0001 one cycle, ack_in=1 continuously -> grants in order 7,5,0,
//    each valid one cycle, separated by one idle cycle; then pending=0.
//  4 grant on code 3 active; same cycle ack_in=1 and req_in=8'h08 -> pending_out[3]=1,
//    valid_out=0 next cycle, code 3 granted again two cycles later.
//  5 en=0, req_in=8'h42 -> pending_out=8'h42, valid_out stays 0; raise en -> code 6 first.
//  6 grant on code 1 active, assert rst one cycle -> valid_out=0, pending=0 next cycle;
//    ack_in pulses with valid_out=0 -> no change in any output.

Source files
------------

// File: rtl/req_enc_pkg.sv
// Shared constants and FSM state encoding for the request encoder block.
package req_enc_pkg;
   localparam int N = 8;
   localparam int W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;
endpackage

// File: rtl/prio_enc8.sv
// Combinational 8->3 priority encoder; the highest set index wins, o_any flags a non-zero input.
module prio_enc8
   import req_enc_pkg::*;
(
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_code,
   output logic         o_any
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      o_code = '0;
      for (int i = 0; i < N; i++) begin
         if (i_vec[i]) begin
            o_code = W'(i);
         end
      end
   end

   assign o_any = |i_vec;

endmodule

// File: rtl/req_encoder8to3.sv
// Sticky request collector that grants one pending index at a time over a valid/ack handshake.
module req_encoder8to3
   import req_enc_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   input  logic         en,
   input  logic         ack_in,
   output logic [W-1:0] code_out,
   output logic         valid_out,
   output logic [N-1:0] pending_out,
   output logic         busy_out
);

   state_t         r_state;
   state_t         w_state_next;
   logic [W-1:0]   r_code;
   logic [W-1:0]   w_code_next;
   logic [N-1:0]   r_pending;
   logic [N-1:0]   w_pending_next;
   logic [N-1:0]   w_clr_mask;
   logic [W-1:0]   w_enc_code;
   logic           w_enc_any;

   prio_enc8 u_prio_enc8 (
      .i_vec  (r_pending),
      .o_code (w_enc_code),
      .o_any  (w_enc_any)
   );

   // Only an accepted grant clears its bit; a same-cycle request on that bit re-sets it.
   for (genvar gi = 0; gi < N; gi++) begin : g_clr
      assign w_clr_mask[gi] = (r_state == GRANT) && ack_in && (r_code == W'(gi));
   end

   assign w_pending_next = (r_pending & ~w_clr_mask) | req_in;

   always_comb begin
      w_state_next = r_state;
      w_code_next  = r_code;
      case (r_state)
         IDLE: begin
            if (en && w_enc_any) begin
               w_code_next  = w_enc_code;
               w_state_next = GRANT;
            end
         end
         GRANT: begin
            if (ack_in) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_code    <= '0;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_next;
         r_code    <= w_code_next;
         r_pending <= w_pending_next;
      end
   end

   assign code_out    = r_code;
   assign valid_out   = (r_state == GRANT);
   assign pending_out = r_pending;
   assign busy_out    = (|r_pending) || (r_state == GRANT);

endmodule

// File: tb/tb_req_encoder8to3.sv
// Scoreboard bench for req_encoder8to3: a cycle model pushes expected outputs, checked after each edge.
module tb_req_encoder8to3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req_in = 8'h00;
   logic       en = 1'b0;
   logic       ack_in = 1'b0;
   logic [2:0] code_out;
   logic       valid_out;
   logic [7:0] pending_out;
   logic       busy_out;

   req_encoder8to3 dut (
      .clk         (clk),
      .rst         (rst),
      .req_in      (req_in),
      .en          (en),
      .ack_in      (ack_in),
      .code_out    (code_out),
      .valid_out   (valid_out),
      .pending_out (pending_out),
      .busy_out    (busy_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] code;
      logic       valid;
      logic [7:0] pend;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   logic [7:0] m_pend  = 8'h00;
   logic       m_valid = 1'b0;
   logic [2:0] m_code  = 3'd0;

   logic       prev_valid = 1'b0;
   int         grants[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [2:0] highest(input logic [7:0] v);
      logic [2:0] h;
      h = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) begin
            h = 3'(i);
            break;
         end
      end
      return h;
   endfunction

   task automatic step(input logic r, input logic [7:0] req, input logic e, input logic a);
      exp_t       x;
      logic [7:0] clr;
      logic [7:0] np;
      logic       nv;
      logic [2:0] nc;
      rst    = r;
      req_in = req;
      en     = e;
      ack_in = a;
      if (r) begin
         np = 8'h00;
         nv = 1'b0;
         nc = 3'd0;
      end else begin
         clr = (m_valid && a) ? (8'h01 << m_code) : 8'h00;
         np  = (m_pend & ~clr) | req;
         nv  = m_valid;
         nc  = m_code;
         if (!m_valid) begin
            if (e && (m_pend != 8'h00)) begin
               nv = 1'b1;
               nc = highest(m_pend);
            end
         end else if (a) begin
            nv = 1'b0;
         end
      end
      m_pend  = np;
      m_valid = nv;
      m_code  = nc;
      x.code  = nc;
      x.valid = nv;
      x.pend  = np;
      x.busy  = (np != 8'h00) || nv;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         x = sb.pop_front();
         chk("valid", 32'(valid_out), 32'(x.valid));
         chk("code", 32'(code_out), 32'(x.code));
         chk("pending", 32'(pending_out), 32'(x.pend));
         chk("busy", 32'(busy_out), 32'(x.busy));
      end
      if (valid_out && !prev_valid) grants.push_back(int'(code_out));
      prev_valid = valid_out;
      $display("t=%0t rst=%b req=%02h en=%b ack=%b -> valid=%b code=%0d pend=%02h busy=%b",
               $time, r, req, e, a, valid_out, code_out, pending_out, busy_out);
   endtask

   initial begin
      // 1: reset dominates requests
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      chk("rst_pending", 32'(pending_out), 32'h00);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_code", 32'(code_out), 32'd0);

      // 2: single request, held grant, then ack
      step(1'b0, 8'h04, 1'b1, 1'b0);
      chk("lat_not_yet", 32'(valid_out), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_code", 32'(code_out), 32'd2);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_hold", 32'(valid_out), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("t2_busy", 32'(busy_out), 32'd0);

      // 3: grant order 7,5,0 with continuous ack
      grants.delete();
      step(1'b0, 8'hA1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("t3_ngrants", 32'(grants.size()), 32'd3);
      if (grants.size() == 3) begin
         chk("t3_g0", 32'(grants[0]), 32'd7);
         chk("t3_g1", 32'(grants[1]), 32'd5);
         chk("t3_g2", 32'(grants[2]), 32'd0);
      end
      chk("t3_pending", 32'(pending_out), 32'h00);

      // 4: set beats clear on the acked bit
      step(1'b0, 8'h08, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h08, 1'b1, 1'b1);
      chk("t4_pend3", 32'(pending_out[3]), 32'd1);
      chk("t4_bubble", 32'(valid_out), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4_regrant", 32'(code_out), 32'd3);
      step(1'b0, 8'h00, 1'b1, 1'b1);

      // 5: en low collects without granting
      step(1'b0, 8'h42, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t5_pending", 32'(pending_out), 32'h42);
      chk("t5_nogrant", 32'(valid_out), 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_first", 32'(code_out), 32'd6);
      step(1'b0, 8'h00, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b1);

      // 6: reset mid-grant, then stray acks
      step(1'b0, 8'h02, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t6_code", 32'(code_out), 32'd1);
      step(1'b1, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("t6_valid", 32'(valid_out), 32'd0);
      chk("t6_pending", 32'(pending_out), 32'h00);

      // Random traffic against the model
      for (int i = 0; i < 60; i++) begin
         logic [7:0] rq;
         rq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         step(1'b0, rq, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
